// File: rtl/jtag_chain_loader.sv
// jtag_chain_loader
//   Host-side driver for the memory scan chain that runs through Imem and then
//   Dmem. Each accepted host word shifts the chain by one position. The word
//   that falls off the end of the chain is handed back to the host. The core
//   is held in reset until a full-length load has completed. A running
//   mod-2^WIDTH sum of the loaded words lets the host verify the image.
//
// Ports
//   clk, rst         clock; synchronous active-low reset
//   start, abort     load control pulses (abort has priority)
//   s_data/valid/ready   host -> chain word stream
//   m_data/valid/ready   chain -> host readback (one-word output slot)
//   Jen, Jin, Jout   chain shift enable, serial word in, last element out
//   core_rst         active-high core reset, low only in DONE
//   busy, done       state == SHIFT / state == DONE
//   count, checksum  words shifted and their sum for the current load
module jtag_chain_loader #(
    parameter int WIDTH       = 32,
    parameter int CHAIN_WORDS = 1024,
    parameter int CW          = $clog2(CHAIN_WORDS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             Jen,
    output logic [WIDTH-1:0] Jin,
    input  logic [WIDTH-1:0] Jout,
    output logic             core_rst,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] checksum
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] m_data_q;
    logic             m_valid_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] checksum_q;

    logic             fire;
    logic [CW-1:0]    count_d;
    logic [WIDTH-1:0] checksum_d;

    // A shift needs room in the output slot: either it is empty or the host
    // is draining it in this same cycle. This is what stops a stalled host
    // from losing chain words.
    assign s_ready    = (state_q == ST_SHIFT) && !abort && (!m_valid_q || m_ready);
    assign fire       = s_valid && s_ready;
    assign Jen        = fire;
    assign Jin        = fire ? s_data : '0;

    assign count_d    = count_q + CW'(1);
    assign checksum_d = checksum_q + s_data;

    assign m_data     = m_data_q;
    assign m_valid    = m_valid_q;
    assign count      = count_q;
    assign checksum   = checksum_q;
    assign core_rst   = (state_q != ST_DONE);
    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            count_q    <= '0;
            checksum_q <= '0;
        end else begin
            // Output slot: a new capture overrides a pop in the same cycle.
            // Jout is sampled before the chain moves, so this is the old word.
            if (fire) begin
                m_data_q  <= Jout;
                m_valid_q <= 1'b1;
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_q    <= ST_SHIFT;
                        count_q    <= '0;
                        checksum_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    // count/checksum are left as-is on abort for debug.
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (fire) begin
                        count_q    <= count_d;
                        checksum_q <= checksum_d;
                        if (count_d == CW'(CHAIN_WORDS)) state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        state_q    <= ST_SHIFT;
                        count_q    <= '0;
                        checksum_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
